rns_mod_addsub_pipe: RTL and testbench
======================================

Name: rns_mod_addsub_pipe

Overview:
- Multi-channel residue-number-system (RNS) modular add/subtract/negate unit.
- Generalises the single-modulus fixed-latency subtractor to NUM_CH independent moduli, a selectable operation, configurable latency and a valid/ready handshake with backpressure.
- Sits between the operand buffers and the RNS error-checking stage of the arithmetic datapath.
- Also flags out-of-range residues for the error-correction logic.

Parameters:
- NUM_CH, 2, number of RNS channels (1..8).
- DATA_WIDTH, 18, width of each residue.
- MODULI, {18'd131071, 18'd177147}, packed NUM_CH*DATA_WIDTH vector.
  - Channel c modulus is MODULI[c*DATA_WIDTH +: DATA_WIDTH].
  - Each modulus is >= 2 and <= 2^DATA_WIDTH-1.
  - Default: ch0 = 177147, ch1 = 131071.
- LATENCY, 2, input-to-output register stages (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  2  00 = A+B, 01 = A-B, 10 = -B, 11 = pass A.
- A  in  NUM_CH*DATA_WIDTH  packed residues of A.
- B  in  NUM_CH*DATA_WIDTH  packed residues of B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  NUM_CH*DATA_WIDTH  packed modular results.
- out_err  out  NUM_CH  per-channel range-error flag (A or B residue >= its modulus).

Behaviour:
- Reset (async assert, sync-released deassert sampling): all stage valid bits, result, and out_err clear to 0. in_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight beats; no partial beat is ever presented.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational).
  - All stages advance together when en = 1; otherwise all stages hold.
  - Bubbles are not compressed.
- A beat is accepted when in_valid && in_ready. Its result appears with out_valid = 1 exactly LATENCY cycles later, provided no backpressure occurred.
- When out_valid && !out_ready, result, out_err and out_valid stay stable until the handshake completes.
- A transfer completes on out_valid && out_ready. A simultaneous accept and transfer in the same cycle is legal and gives full throughput of one beat per cycle.
- Per-channel arithmetic (M = channel modulus, W = DATA_WIDTH):
  - add: s = A+B computed in W+1 bits; result = s-M if s >= M, else s.
  - sub: result = A-B if A >= B, else A-B+M.
  - neg: result = 0 if B == 0, else M-B.
  - pass: result = A.
- Range error: err_c = (A_c >= M) || (B_c >= M), with op-independent checking of both operands.
  - When err_c = 1, result for channel c is forced to 0 and out_err[c] = 1, registered with the beat.
- Stage split:
  - LATENCY = 1: single output register.
  - LATENCY = 2: stage 1 registers the raw value, the corrected candidate and err; stage 2 selects and registers.
  - LATENCY = 3: adds a further output register after the LATENCY = 2 structure.
- No intermediate value wider than W+1 bits. Moduli are constants; no runtime modulus.
- Channels are fully independent; out_valid is common to all channels.
- An illegal LATENCY or a modulus outside range is a static elaboration error (use $error in a generate check).

Test Plan:
- Defaults, out_ready = 1:
  - op = sub, A = {0,0}, B = {1,1} -> result ch0 = 177146, ch1 = 131070, exactly 2 cycles after accept.
  - op = sub, ch0 100000-100001 -> 177146; ch0 2-1 -> 1; ch0 2-2 -> 0.
- op = add, ch0 177146+1 -> 0; ch1 131070+131070 -> 131069; ch0 5+7 -> 12. op = neg, B = {0,5} -> ch0 = 177142, ch1 = 0.
- Range error: op = add, ch0 A = 177147, B = 3 -> out_err = 2'b01 and ch0 result 0, while ch1 computes normally.
- Backpressure: stream 6 beats, drop out_ready for 5 cycles on beat 2.
  - result and out_valid hold, in_ready = 0 during the stall.
  - All 6 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst_n = 0 with 2 beats in flight -> out_valid = 0 and result = 0 immediately. No stale beat appears after release.
- Sweep LATENCY = 1, 2, 3 with the exhaustive ch0 sub check of 4096 random pairs against the reference model (i<j ? i-j+M : i-j) -> zero mismatches and latency equal to LATENCY.

Source files
------------

// File: rtl/rns_mod_addsub_pipe.sv
// Multi-channel RNS modular add/sub/negate/pass unit with a configurable-latency
// pipeline, valid/ready handshake and per-channel out-of-range residue flags.
`timescale 1ns / 1ps

module rns_mod_addsub_pipe #(
  parameter int unsigned                        NUM_CH     = 2,
  parameter int unsigned                        DATA_WIDTH = 18,
  parameter logic [NUM_CH*DATA_WIDTH-1:0]       MODULI     = {18'd131071, 18'd177147},
  parameter int unsigned                        LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   op,
  input  logic [NUM_CH*DATA_WIDTH-1:0] A,
  input  logic [NUM_CH*DATA_WIDTH-1:0] B,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] result,
  output logic [NUM_CH-1:0]            out_err
);

  localparam int unsigned W          = DATA_WIDTH;
  localparam int unsigned PostStages = (LATENCY <= 1) ? 1 : LATENCY - 1;

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("rns_mod_addsub_pipe: LATENCY must be 1..3");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("rns_mod_addsub_pipe: NUM_CH must be 1..8");
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_mod_chk
    if (MODULI[g*DATA_WIDTH +: DATA_WIDTH] < 2) begin : g_bad_mod
      $error("rns_mod_addsub_pipe: modulus must be >= 2");
    end
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Front end: raw value, modular-corrected candidate and which one to use.
  logic [NUM_CH-1:0][W-1:0] raw_d, cand_d;
  logic [NUM_CH-1:0]        usec_d, rerr_d;

  always_comb begin
    logic [W-1:0] a_c, b_c, m_c;
    logic [W:0]   sum_c, dif_c;
    raw_d  = '0;
    cand_d = '0;
    usec_d = '0;
    rerr_d = '0;
    a_c    = '0;
    b_c    = '0;
    m_c    = '0;
    sum_c  = '0;
    dif_c  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      a_c   = A[c*W +: W];
      b_c   = B[c*W +: W];
      m_c   = MODULI[c*W +: W];
      sum_c = {1'b0, a_c} + {1'b0, b_c};
      dif_c = {1'b0, a_c} - {1'b0, b_c};
      unique case (op)
        2'b00: begin
          raw_d[c]  = sum_c[W-1:0];
          cand_d[c] = sum_c[W-1:0] - m_c;
          usec_d[c] = sum_c >= {1'b0, m_c};
        end
        2'b01: begin
          raw_d[c]  = dif_c[W-1:0];
          cand_d[c] = a_c - b_c + m_c;  // wraps in W bits; true value < M
          usec_d[c] = dif_c[W];
        end
        2'b10: begin
          raw_d[c]  = '0;
          cand_d[c] = m_c - b_c;
          usec_d[c] = (b_c != '0);
        end
        2'b11: begin
          raw_d[c]  = a_c;
          cand_d[c] = '0;
          usec_d[c] = 1'b0;
        end
      endcase
      rerr_d[c] = (a_c >= m_c) || (b_c >= m_c);
    end
  end

  logic [NUM_CH-1:0][W-1:0] s_raw, s_cand;
  logic [NUM_CH-1:0]        s_usec, s_err;

  if (LATENCY >= 2) begin : g_split
    logic [NUM_CH-1:0][W-1:0] raw_q, cand_q;
    logic [NUM_CH-1:0]        usec_q, rerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        raw_q  <= '0;
        cand_q <= '0;
        usec_q <= '0;
        rerr_q <= '0;
      end else if (en) begin
        raw_q  <= raw_d;
        cand_q <= cand_d;
        usec_q <= usec_d;
        rerr_q <= rerr_d;
      end
    end

    assign s_raw  = raw_q;
    assign s_cand = cand_q;
    assign s_usec = usec_q;
    assign s_err  = rerr_q;
  end else begin : g_flat
    assign s_raw  = raw_d;
    assign s_cand = cand_d;
    assign s_usec = usec_d;
    assign s_err  = rerr_d;
  end

  logic [NUM_CH*W-1:0] sel_res;
  logic [NUM_CH-1:0]   sel_err;

  always_comb begin
    sel_res = '0;
    sel_err = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_err[c]         = s_err[c];
      sel_res[c*W +: W]  = s_err[c] ? '0 : (s_usec[c] ? s_cand[c] : s_raw[c]);
    end
  end

  // Output register chain; all stages share the single enable so bubbles persist.
  logic [PostStages-1:0][NUM_CH*W-1:0] res_q, res_d;
  logic [PostStages-1:0][NUM_CH-1:0]   err_q, err_d;
  logic [LATENCY-1:0]                  vld_q, vld_d;

  always_comb begin
    res_d    = res_q;
    err_d    = err_q;
    res_d[0] = sel_res;
    err_d[0] = sel_err;
    for (int i = 1; i < PostStages; i++) begin
      res_d[i] = res_q[i-1];
      err_d[i] = err_q[i-1];
    end
  end

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      err_q <= '0;
      vld_q <= '0;
    end else if (en) begin
      res_q <= res_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign result    = res_q[PostStages-1];
  assign out_err   = err_q[PostStages-1];

endmodule

// File: tb/tb_rns_mod_addsub_pipe.sv
// Bench for rns_mod_addsub_pipe: directed cases and backpressure/reset on LATENCY=2,
// plus a random sweep of LATENCY=1,2,3 against an arithmetic reference model.
`timescale 1ns / 1ps

module tb_rns_mod_addsub_pipe;

  localparam int unsigned M0   = 177147;
  localparam int unsigned M1   = 131071;
  localparam int          NSUB = 4096;
  localparam int          NMIX = 600;
  localparam int          NSW  = NSUB + NMIX + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  op;
  logic [35:0] A, B;

  logic        rdy1, rdy2, rdy3;
  logic        ov1, ov2, ov3;
  logic [35:0] res1, res2, res3;
  logic [1:0]  err1, err2, err3;

  int total = 0;
  int bad   = 0;

  bit          hist_v [NSW];
  logic [37:0] hist_x [NSW];

  always #5 clk = ~clk;

  rns_mod_addsub_pipe #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .op(op), .A(A), .B(B),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .out_err(err1));
  rns_mod_addsub_pipe #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .op(op), .A(A), .B(B),
    .out_valid(ov2), .out_ready(out_ready), .result(res2), .out_err(err2));
  rns_mod_addsub_pipe #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .op(op), .A(A), .B(B),
    .out_valid(ov3), .out_ready(out_ready), .result(res3), .out_err(err3));

  // Reference: one channel, {err, residue}, from plain modular arithmetic.
  function automatic logic [18:0] ref_ch(input logic [1:0] o, input longint a, input longint b,
                                         input longint m);
    longint r;
    if (a >= m || b >= m) return 19'd0 | (19'd1 << 18);
    case (o)
      2'd0:    r = (a + b) % m;
      2'd1:    r = (a - b + m) % m;
      2'd2:    r = (m - b) % m;
      default: r = a;
    endcase
    return {1'b0, 18'(r)};
  endfunction

  function automatic logic [37:0] model(input logic [1:0] o, input logic [35:0] a,
                                        input logic [35:0] b);
    logic [18:0] c0, c1;
    c0 = ref_ch(o, longint'(a[17:0]), longint'(b[17:0]), longint'(M0));
    c1 = ref_ch(o, longint'(a[35:18]), longint'(b[35:18]), longint'(M1));
    return {c1[18], c0[18], c1[17:0], c0[17:0]};
  endfunction

  function automatic logic [35:0] pk(input int unsigned c1, input int unsigned c0);
    return {18'(c1), 18'(c0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Single beat on an idle LATENCY=2 pipe; entered and left just after a rising edge.
  task automatic beat(input string tag, input logic [1:0] o, input logic [35:0] a,
                      input logic [35:0] b, input logic [35:0] exp_r, input logic [1:0] exp_e);
    int lat;
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge clk);
    chk({tag, "_rdy"}, rdy2, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (ov2) break;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_res"}, res2, exp_r);
    chk({tag, "_err"}, err2, exp_e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lat(input string tag, input int lat, input int k, input logic ov,
                         input logic [37:0] got);
    logic ev;
    ev = (k >= lat) ? hist_v[k-lat] : 1'b0;
    chk({tag, "_valid"}, ov, ev);
    if (ev) chk({tag, "_data"}, got, hist_x[k-lat]);
  endtask

  initial begin
    logic [1:0]  bp_op [6];
    logic [35:0] bp_a  [6];
    logic [35:0] bp_b  [6];
    logic [37:0] bp_x  [6];
    int          sent, rcv, stall;
    bit          stalling;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 2'd0;
    A = '0;
    B = '0;
    #1;
    chk("rst_valid", ov2, 0);
    chk("rst_result", res2, 0);
    chk("rst_err", err2, 0);
    chk("rst_ready", rdy2, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    beat("sub0", 2'd1, pk(0, 0), pk(1, 1), pk(131070, 177146), 2'b00);
    beat("sub1", 2'd1, pk(0, 100000), pk(0, 100001), pk(0, 177146), 2'b00);
    beat("sub2", 2'd1, pk(0, 2), pk(0, 1), pk(0, 1), 2'b00);
    beat("sub3", 2'd1, pk(0, 2), pk(0, 2), pk(0, 0), 2'b00);
    beat("add0", 2'd0, pk(131070, 177146), pk(131070, 1), pk(131069, 0), 2'b00);
    beat("add1", 2'd0, pk(0, 5), pk(0, 7), pk(0, 12), 2'b00);
    beat("neg0", 2'd2, pk(0, 0), pk(0, 5), pk(0, 177142), 2'b00);
    beat("err0", 2'd0, pk(10, 177147), pk(20, 3), pk(30, 0), 2'b01);
    beat("pass", 2'd3, pk(1234, 99), pk(262143, 7), pk(0, 99), 2'b10);

    // Backpressure: six beats, output stalled for five cycles while beat 2 is presented.
    for (int i = 0; i < 6; i++) begin
      bp_op[i] = 2'($urandom_range(0, 3));
      bp_a[i]  = pk($urandom_range(0, M1 - 1), $urandom_range(0, M0 - 1));
      bp_b[i]  = pk($urandom_range(0, M1 - 1), $urandom_range(0, M0 - 1));
      bp_x[i]  = model(bp_op[i], bp_a[i], bp_b[i]);
    end
    sent = 0;
    rcv = 0;
    stall = 0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      stalling = (rcv == 2) && ov2 && (stall < 5);
      out_ready = !stalling;
      in_valid = (sent < 6);
      if (sent < 6) begin
        op = bp_op[sent];
        A = bp_a[sent];
        B = bp_b[sent];
      end
      @(negedge clk);
      if (stalling) begin
        chk("bp_stall_ready", rdy2, 0);
        chk("bp_stall_valid", ov2, 1);
        chk("bp_stall_hold", {err2, res2}, bp_x[rcv]);
        stall++;
      end else if (ov2) begin
        chk("bp_order", {err2, res2}, bp_x[rcv]);
        rcv++;
      end
      if (in_valid && rdy2) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_received", rcv, 6);
    chk("bp_stall_cycles", stall, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_no_extra", ov2, 0);
    end
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    in_valid = 1'b1;
    op = 2'd0;
    A = pk(100, 200);
    B = pk(300, 400);
    @(posedge clk);
    #1 A = pk(7, 8);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", ov2, 0);
    chk("mrst_result", res2, 0);
    chk("mrst_err", err2, 0);
    chk("mrst_ready", rdy2, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_stale", {ov3, ov2, ov1}, 0);
    end
    @(posedge clk);
    #1;

    // Latency sweep: all three pipes see the same stream with out_ready held high.
    for (int k = 0; k < NSW; k++) begin
      if (k < NSUB) begin
        in_valid = 1'b1;
        op = 2'd1;
        A = pk($urandom_range(0, M1 - 1), $urandom_range(0, M0 - 1));
        B = pk($urandom_range(0, M1 - 1), $urandom_range(0, M0 - 1));
      end else begin
        in_valid = (k < NSUB + NMIX) && ($urandom_range(0, 3) != 0);
        op = 2'($urandom_range(0, 3));
        A = pk($urandom_range(0, 262143), $urandom_range(0, 262143));
        B = pk($urandom_range(0, 262143), $urandom_range(0, 262143));
      end
      hist_v[k] = in_valid;
      hist_x[k] = model(op, A, B);
      @(negedge clk);
      chk("sw_ready", {rdy3, rdy2, rdy1}, 3'b111);
      chk_lat("sw_l1", 1, k, ov1, {err1, res1});
      chk_lat("sw_l2", 2, k, ov2, {err2, res2});
      chk_lat("sw_l3", 3, k, ov3, {err3, res3});
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
